// File: rtl/dbg_abscmd_pkg.sv
// Shared types and constants for the debug-module abstract command initiator.
// Holds the FSM state encoding, cmderr codes, dport special addresses and the
// register bundle (with its reset value) used by dbg_abscmd_initiator.
package dbg_abscmd_pkg;

    localparam int unsigned CNT_W  = 16;
    localparam int unsigned DATA_W = 64;
    localparam int unsigned ADDR_W = 16;

    // State encodings; IDLE is all-zero so the reset bundle can be '0.
    localparam logic [2:0] S_IDLE      = 3'd0;
    localparam logic [2:0] S_XFER_REQ  = 3'd1;
    localparam logic [2:0] S_XFER_RESP = 3'd2;
    localparam logic [2:0] S_EXEC_REQ  = 3'd3;
    localparam logic [2:0] S_EXEC_RESP = 3'd4;
    localparam logic [2:0] S_DONE      = 3'd5;

    typedef enum logic [2:0] {
        ST_IDLE      = S_IDLE,
        ST_XFER_REQ  = S_XFER_REQ,
        ST_XFER_RESP = S_XFER_RESP,
        ST_EXEC_REQ  = S_EXEC_REQ,
        ST_EXEC_RESP = S_EXEC_RESP,
        ST_DONE      = S_DONE
    } state_t;

    // Abstract command error codes.
    localparam logic [2:0] CMDERR_NONE       = 3'd0;
    localparam logic [2:0] CMDERR_BUSY       = 3'd1;
    localparam logic [2:0] CMDERR_NOTSUP     = 3'd2;
    localparam logic [2:0] CMDERR_EXCEPT     = 3'd3;
    localparam logic [2:0] CMDERR_HALTRESUME = 3'd4;

    localparam logic [2:0] AARSIZE_32 = 3'd2;
    localparam logic [2:0] AARSIZE_64 = 3'd3;
    localparam logic [1:0] SIZE_64    = 2'd3;

    // Dport address that triggers program-buffer execution.
    localparam logic [ADDR_W-1:0] DPORT_PROGBUF_EXEC = 16'hFFFF;

    // Every flop of the initiator; outputs are driven straight from here.
    typedef struct packed {
        state_t              state;
        logic [CNT_W-1:0]    cnt;
        logic [2:0]          cmderr;
        logic                busy;
        logic [DATA_W-1:0]   data0;
        logic                data0_we;
        logic                req_valid;
        logic                resp_ready;
        logic                write;
        logic [ADDR_W-1:0]   addr;
        logic [DATA_W-1:0]   wdata;
        logic [1:0]          size;
        logic                postexec;
    } regs_t;

    localparam regs_t REGS_RESET = '0;

endpackage

// File: rtl/dbg_abscmd_initiator.sv
// Abstract "access register" command initiator towards the core debug port.
// Ports:
//   i_clk, i_rst               clock, synchronous active-high reset
//   i_cmd_*                    command strobe and decoded command fields
//   i_data0                    data0 value used as write data
//   i_cmderr_clr               W1C strobe for cmderr
//   i_halted                   core halted status
//   o_busy, o_cmderr           abstractcs status
//   o_data0, o_data0_we        read result and its 1-cycle update strobe
//   o_dport_* / i_dport_*      debug port request/response handshakes
module dbg_abscmd_initiator
    import dbg_abscmd_pkg::*;
#(
    parameter int unsigned TIMEOUT_CYCLES = 1024
) (
    input  logic              i_clk,
    input  logic              i_rst,
    input  logic              i_cmd_valid,
    input  logic              i_cmd_transfer,
    input  logic              i_cmd_postexec,
    input  logic              i_cmd_write,
    input  logic [2:0]        i_cmd_aarsize,
    input  logic [15:0]       i_cmd_regno,
    input  logic [63:0]       i_data0,
    input  logic              i_cmderr_clr,
    input  logic              i_halted,
    output logic              o_busy,
    output logic [2:0]        o_cmderr,
    output logic [63:0]       o_data0,
    output logic              o_data0_we,
    output logic              o_dport_req_valid,
    input  logic              i_dport_req_ready,
    output logic              o_dport_write,
    output logic [15:0]       o_dport_addr,
    output logic [63:0]       o_dport_wdata,
    output logic [1:0]        o_dport_size,
    input  logic              i_dport_resp_valid,
    output logic              o_dport_resp_ready,
    input  logic              i_dport_resp_error,
    input  logic [63:0]       i_dport_rdata
);

    localparam logic [CNT_W-1:0] TMO_LAST = CNT_W'(TIMEOUT_CYCLES - 1);

    regs_t      r_regs;
    regs_t      w_next;
    logic       w_set;
    logic [2:0] w_code;
    logic       w_tmo;

    // State/output register.
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_regs <= REGS_RESET;
        end else begin
            r_regs <= w_next;
        end
    end

    assign w_tmo = (r_regs.cnt == TMO_LAST);

    // Next-state and next-output logic.
    always_comb begin
        w_next          = r_regs;
        w_next.data0_we = 1'b0;
        w_set           = 1'b0;
        w_code          = CMDERR_NONE;

        unique case (r_regs.state)
            ST_IDLE: begin
                // A pending error blocks new commands until cleared.
                if (i_cmd_valid && (r_regs.cmderr == CMDERR_NONE)) begin
                    if (!i_halted) begin
                        w_set  = 1'b1;
                        w_code = CMDERR_HALTRESUME;
                    end else if (i_cmd_transfer &&
                                 (i_cmd_aarsize != AARSIZE_32) &&
                                 (i_cmd_aarsize != AARSIZE_64)) begin
                        w_set  = 1'b1;
                        w_code = CMDERR_NOTSUP;
                    end else if (i_cmd_transfer) begin
                        w_next.state     = ST_XFER_REQ;
                        w_next.req_valid = 1'b1;
                        w_next.write     = i_cmd_write;
                        w_next.addr      = i_cmd_regno;
                        w_next.wdata     = i_data0;
                        w_next.size      = i_cmd_aarsize[1:0];
                        w_next.postexec  = i_cmd_postexec;
                    end else if (i_cmd_postexec) begin
                        w_next.state     = ST_EXEC_REQ;
                        w_next.req_valid = 1'b1;
                        w_next.write     = 1'b0;
                        w_next.addr      = DPORT_PROGBUF_EXEC;
                        w_next.postexec  = 1'b0;
                    end else begin
                        w_next.state = ST_DONE;
                    end
                end
            end

            ST_XFER_REQ, ST_EXEC_REQ: begin
                if (i_dport_req_ready) begin
                    w_next.state      = (r_regs.state == ST_XFER_REQ) ? ST_XFER_RESP
                                                                      : ST_EXEC_RESP;
                    w_next.req_valid  = 1'b0;
                    w_next.resp_ready = 1'b1;
                end else if (w_tmo) begin
                    w_next.state     = ST_DONE;
                    w_next.req_valid = 1'b0;
                    w_set            = 1'b1;
                    w_code           = CMDERR_EXCEPT;
                end else begin
                    w_next.cnt = r_regs.cnt + CNT_W'(1);
                end
            end

            ST_XFER_RESP: begin
                if (i_dport_resp_valid) begin
                    w_next.resp_ready = 1'b0;
                    if (i_dport_resp_error) begin
                        w_next.state = ST_DONE;
                        w_set        = 1'b1;
                        w_code       = CMDERR_EXCEPT;
                    end else begin
                        if (!r_regs.write) begin
                            w_next.data0    = (r_regs.size == SIZE_64) ? i_dport_rdata
                                              : {32'h0, i_dport_rdata[31:0]};
                            w_next.data0_we = 1'b1;
                        end
                        if (r_regs.postexec) begin
                            w_next.state     = ST_EXEC_REQ;
                            w_next.req_valid = 1'b1;
                            w_next.write     = 1'b0;
                            w_next.addr      = DPORT_PROGBUF_EXEC;
                            w_next.postexec  = 1'b0;
                        end else begin
                            w_next.state = ST_DONE;
                        end
                    end
                end else if (w_tmo) begin
                    w_next.state      = ST_DONE;
                    w_next.resp_ready = 1'b0;
                    w_set             = 1'b1;
                    w_code            = CMDERR_EXCEPT;
                end else begin
                    w_next.cnt = r_regs.cnt + CNT_W'(1);
                end
            end

            ST_EXEC_RESP: begin
                if (i_dport_resp_valid) begin
                    w_next.resp_ready = 1'b0;
                    w_next.state      = ST_DONE;
                    if (i_dport_resp_error) begin
                        w_set  = 1'b1;
                        w_code = CMDERR_EXCEPT;
                    end
                end else if (w_tmo) begin
                    w_next.state      = ST_DONE;
                    w_next.resp_ready = 1'b0;
                    w_set             = 1'b1;
                    w_code            = CMDERR_EXCEPT;
                end else begin
                    w_next.cnt = r_regs.cnt + CNT_W'(1);
                end
            end

            ST_DONE: begin
                w_next.state = ST_IDLE;
            end

            default: begin
                w_next = REGS_RESET;
            end
        endcase

        // Command written while a previous one is still running.
        if (i_cmd_valid && (r_regs.state != ST_IDLE) && !w_set) begin
            w_set  = 1'b1;
            w_code = CMDERR_BUSY;
        end

        // Timeout counter restarts on every state change.
        if (w_next.state != r_regs.state) begin
            w_next.cnt = '0;
        end

        w_next.busy = (w_next.state != ST_IDLE);

        // Sticky error: only set from zero; a set beats a same-cycle clear.
        if (w_set && (r_regs.cmderr == CMDERR_NONE)) begin
            w_next.cmderr = w_code;
        end else if (i_cmderr_clr) begin
            w_next.cmderr = CMDERR_NONE;
        end
    end

    assign o_busy             = r_regs.busy;
    assign o_cmderr           = r_regs.cmderr;
    assign o_data0            = r_regs.data0;
    assign o_data0_we         = r_regs.data0_we;
    assign o_dport_req_valid  = r_regs.req_valid;
    assign o_dport_write      = r_regs.write;
    assign o_dport_addr       = r_regs.addr;
    assign o_dport_wdata      = r_regs.wdata;
    assign o_dport_size       = r_regs.size;
    assign o_dport_resp_ready = r_regs.resp_ready;

endmodule

// File: tb/tb_dbg_abscmd_initiator.sv
// Scoreboard bench for dbg_abscmd_initiator: directed commands push expected
// dport requests and data0 updates; a negedge monitor pops and compares.
module tb_dbg_abscmd_initiator;

    logic        clk;
    logic        i_rst;
    logic        i_cmd_valid;
    logic        i_cmd_transfer;
    logic        i_cmd_postexec;
    logic        i_cmd_write;
    logic [2:0]  i_cmd_aarsize;
    logic [15:0] i_cmd_regno;
    logic [63:0] i_data0;
    logic        i_cmderr_clr;
    logic        i_halted;
    logic        o_busy;
    logic [2:0]  o_cmderr;
    logic [63:0] o_data0;
    logic        o_data0_we;
    logic        o_dport_req_valid;
    logic        i_dport_req_ready;
    logic        o_dport_write;
    logic [15:0] o_dport_addr;
    logic [63:0] o_dport_wdata;
    logic [1:0]  o_dport_size;
    logic        i_dport_resp_valid;
    logic        o_dport_resp_ready;
    logic        i_dport_resp_error;
    logic [63:0] i_dport_rdata;

    dbg_abscmd_initiator #(.TIMEOUT_CYCLES(16)) dut (
        .i_clk              (clk),
        .i_rst              (i_rst),
        .i_cmd_valid        (i_cmd_valid),
        .i_cmd_transfer     (i_cmd_transfer),
        .i_cmd_postexec     (i_cmd_postexec),
        .i_cmd_write        (i_cmd_write),
        .i_cmd_aarsize      (i_cmd_aarsize),
        .i_cmd_regno        (i_cmd_regno),
        .i_data0            (i_data0),
        .i_cmderr_clr       (i_cmderr_clr),
        .i_halted           (i_halted),
        .o_busy             (o_busy),
        .o_cmderr           (o_cmderr),
        .o_data0            (o_data0),
        .o_data0_we         (o_data0_we),
        .o_dport_req_valid  (o_dport_req_valid),
        .i_dport_req_ready  (i_dport_req_ready),
        .o_dport_write      (o_dport_write),
        .o_dport_addr       (o_dport_addr),
        .o_dport_wdata      (o_dport_wdata),
        .o_dport_size       (o_dport_size),
        .i_dport_resp_valid (i_dport_resp_valid),
        .o_dport_resp_ready (o_dport_resp_ready),
        .i_dport_resp_error (i_dport_resp_error),
        .i_dport_rdata      (i_dport_rdata)
    );

    typedef struct packed {
        logic        write;
        logic [15:0] addr;
        logic [63:0] wdata;
        logic [1:0]  size;
    } req_t;

    req_t        exp_req[$];
    logic [63:0] exp_d0[$];
    int          checks = 0;
    int          errors = 0;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Monitor: compares every presented request and data0 update against the scoreboard.
    always @(negedge clk) begin
        if (!i_rst) begin
            if (o_dport_req_valid) begin
                if (exp_req.size() == 0) begin
                    check("unexpected_req", {48'h0, o_dport_addr}, 64'hFFFF_FFFF_FFFF_FFFF);
                end else begin
                    check("req_write", 64'(o_dport_write), 64'(exp_req[0].write));
                    check("req_addr", 64'(o_dport_addr), 64'(exp_req[0].addr));
                    if (exp_req[0].write) begin
                        check("req_wdata", o_dport_wdata, exp_req[0].wdata);
                        check("req_size", 64'(o_dport_size), 64'(exp_req[0].size));
                    end
                    if (i_dport_req_ready) void'(exp_req.pop_front());
                end
            end
            if (o_data0_we) begin
                if (exp_d0.size() == 0) begin
                    check("unexpected_data0_we", o_data0, 64'hFFFF_FFFF_FFFF_FFFF);
                end else begin
                    check("data0", o_data0, exp_d0.pop_front());
                end
            end
        end
    end

    task automatic issue(input logic transfer, input logic postexec, input logic write,
                         input logic [2:0] aarsize, input logic [15:0] regno,
                         input logic [63:0] d0);
        i_cmd_valid    = 1'b1;
        i_cmd_transfer = transfer;
        i_cmd_postexec = postexec;
        i_cmd_write    = write;
        i_cmd_aarsize  = aarsize;
        i_cmd_regno    = regno;
        i_data0        = d0;
        tick();
        i_cmd_valid    = 1'b0;
    endtask

    task automatic serve_req(input int delay);
        for (int i = 0; i < 50 && !o_dport_req_valid; i++) tick();
        check("req_valid_seen", 64'(o_dport_req_valid), 64'd1);
        for (int i = 0; i < delay; i++) tick();
        i_dport_req_ready = 1'b1;
        tick();
        i_dport_req_ready = 1'b0;
    endtask

    task automatic serve_resp(input int delay, input logic err, input logic [63:0] rdata);
        for (int i = 0; i < 50 && !o_dport_resp_ready; i++) tick();
        check("resp_ready_seen", 64'(o_dport_resp_ready), 64'd1);
        for (int i = 0; i < delay; i++) tick();
        i_dport_resp_valid = 1'b1;
        i_dport_resp_error = err;
        i_dport_rdata      = rdata;
        tick();
        i_dport_resp_valid = 1'b0;
        i_dport_resp_error = 1'b0;
        i_dport_rdata      = '0;
    endtask

    task automatic wait_idle();
        for (int i = 0; i < 50 && o_busy; i++) tick();
        check("busy_falls", 64'(o_busy), 64'd0);
    endtask

    task automatic clear_err();
        i_cmderr_clr = 1'b1;
        tick();
        i_cmderr_clr = 1'b0;
        check("cmderr_cleared", 64'(o_cmderr), 64'd0);
    endtask

    initial begin
        int n;
        i_rst = 1'b1;
        i_cmd_valid = 0; i_cmd_transfer = 0; i_cmd_postexec = 0; i_cmd_write = 0;
        i_cmd_aarsize = 0; i_cmd_regno = 0; i_data0 = 0; i_cmderr_clr = 0;
        i_halted = 1'b1; i_dport_req_ready = 0; i_dport_resp_valid = 0;
        i_dport_resp_error = 0; i_dport_rdata = 0;
        tick(); tick();
        i_rst = 1'b0;

        // Reset state
        check("rst_busy", 64'(o_busy), 64'd0);
        check("rst_cmderr", 64'(o_cmderr), 64'd0);
        check("rst_req_valid", 64'(o_dport_req_valid), 64'd0);
        check("rst_resp_ready", 64'(o_dport_resp_ready), 64'd0);
        check("rst_data0", o_data0, 64'd0);
        check("rst_data0_we", 64'(o_data0_we), 64'd0);

        // 64-bit read with a 3-cycle ready delay
        exp_req.push_back('{write: 1'b0, addr: 16'h1001, wdata: 64'h0, size: 2'd3});
        exp_d0.push_back(64'h1122334455667788);
        issue(1, 0, 0, 3'd3, 16'h1001, 64'h0);
        check("rd64_busy", 64'(o_busy), 64'd1);
        serve_req(3);
        check("rd64_busy_resp", 64'(o_busy), 64'd1);
        serve_resp(0, 0, 64'h1122334455667788);
        wait_idle();
        check("rd64_cmderr", 64'(o_cmderr), 64'd0);
        check("rd64_data0", o_data0, 64'h1122334455667788);

        // 32-bit write, request stalled 5 cycles (monitor checks fields every stall cycle)
        exp_req.push_back('{write: 1'b1, addr: 16'h0300, wdata: 64'hDEADBEEF_CAFEF00D, size: 2'd2});
        issue(1, 0, 1, 3'd2, 16'h0300, 64'hDEADBEEF_CAFEF00D);
        serve_req(5);
        serve_resp(1, 0, 64'h5555_5555_5555_5555);
        wait_idle();
        check("wr_cmderr", 64'(o_cmderr), 64'd0);
        check("wr_data0_kept", o_data0, 64'h1122334455667788);

        // 32-bit read followed by progbuf exec
        exp_req.push_back('{write: 1'b0, addr: 16'h1002, wdata: 64'h0, size: 2'd2});
        exp_req.push_back('{write: 1'b0, addr: 16'hFFFF, wdata: 64'h0, size: 2'd0});
        exp_d0.push_back(64'h0000_0000_1234_5678);
        issue(1, 1, 0, 3'd2, 16'h1002, 64'h0);
        serve_req(0);
        serve_resp(0, 0, 64'hAAAA_BBBB_1234_5678);
        serve_req(1);
        serve_resp(0, 0, 64'h0);
        wait_idle();
        check("pe_cmderr", 64'(o_cmderr), 64'd0);
        check("pe_data0", o_data0, 64'h0000_0000_1234_5678);

        // Transfer error: no exec request, no data0 update
        exp_req.push_back('{write: 1'b0, addr: 16'h1003, wdata: 64'h0, size: 2'd3});
        issue(1, 1, 0, 3'd3, 16'h1003, 64'h0);
        serve_req(0);
        serve_resp(0, 1, 64'h9999_9999_9999_9999);
        wait_idle();
        repeat (4) tick();
        check("err_cmderr", 64'(o_cmderr), 64'd3);
        check("err_data0_kept", o_data0, 64'h0000_0000_1234_5678);
        clear_err();

        // Not halted
        i_halted = 1'b0;
        issue(1, 0, 0, 3'd3, 16'h1001, 64'h0);
        i_halted = 1'b1;
        check("nohalt_cmderr", 64'(o_cmderr), 64'd4);
        check("nohalt_busy", 64'(o_busy), 64'd0);
        repeat (3) tick();
        clear_err();

        // Unsupported size
        issue(1, 0, 0, 3'd1, 16'h1001, 64'h0);
        check("notsup_cmderr", 64'(o_cmderr), 64'd2);
        check("notsup_busy", 64'(o_busy), 64'd0);
        clear_err();

        // Command while busy: flagged, running command still completes
        exp_req.push_back('{write: 1'b0, addr: 16'h1004, wdata: 64'h0, size: 2'd3});
        exp_d0.push_back(64'hCAFE_0000_BEEF_1111);
        issue(1, 0, 0, 3'd3, 16'h1004, 64'h0);
        issue(1, 0, 1, 3'd3, 16'h2222, 64'h0);
        check("busy_cmderr", 64'(o_cmderr), 64'd1);
        check("busy_still", 64'(o_busy), 64'd1);
        serve_req(1);
        serve_resp(0, 0, 64'hCAFE_0000_BEEF_1111);
        wait_idle();
        check("busy_data0", o_data0, 64'hCAFE_0000_BEEF_1111);
        check("busy_cmderr_sticky", 64'(o_cmderr), 64'd1);
        clear_err();

        // Request never accepted: timeout after 16 cycles
        exp_req.push_back('{write: 1'b1, addr: 16'h07B0, wdata: 64'h0123_4567_89AB_CDEF, size: 2'd3});
        issue(1, 0, 1, 3'd3, 16'h07B0, 64'h0123_4567_89AB_CDEF);
        n = 0;
        while (o_dport_req_valid && n < 40) begin
            n++;
            tick();
        end
        exp_req.delete();
        check("tmo_valid_cycles", 64'(n), 64'd16);
        check("tmo_cmderr", 64'(o_cmderr), 64'd3);
        wait_idle();
        clear_err();

        // Reset while waiting for the response, then a normal command
        exp_req.push_back('{write: 1'b0, addr: 16'h1005, wdata: 64'h0, size: 2'd3});
        issue(1, 0, 0, 3'd3, 16'h1005, 64'h0);
        serve_req(0);
        check("mid_resp_ready", 64'(o_dport_resp_ready), 64'd1);
        i_rst = 1'b1;
        tick();
        i_rst = 1'b0;
        check("mid_rst_busy", 64'(o_busy), 64'd0);
        check("mid_rst_req_valid", 64'(o_dport_req_valid), 64'd0);
        check("mid_rst_resp_ready", 64'(o_dport_resp_ready), 64'd0);
        exp_req.push_back('{write: 1'b0, addr: 16'h1006, wdata: 64'h0, size: 2'd3});
        exp_d0.push_back(64'h0F0E_0D0C_0B0A_0908);
        issue(1, 0, 0, 3'd3, 16'h1006, 64'h0);
        serve_req(2);
        serve_resp(2, 0, 64'h0F0E_0D0C_0B0A_0908);
        wait_idle();
        check("post_rst_data0", o_data0, 64'h0F0E_0D0C_0B0A_0908);
        check("post_rst_cmderr", 64'(o_cmderr), 64'd0);

        repeat (3) tick();
        check("req_queue_empty", 64'(exp_req.size()), 64'd0);
        check("data0_queue_empty", 64'(exp_d0.size()), 64'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
